// File: rtl/spi_io_pkg.sv
`default_nettype none
// ============================================================================
// spi_io_pkg : shared constants, parameter limits and helpers for spi_io_retimer
// Revision   : 1.0
// ============================================================================
package spi_io_pkg;

  localparam int GUARD_CNT_W      = 3;
  localparam int SS_WIDTH_MAX     = 32;
  localparam int OUT_STAGES_MIN   = 1;
  localparam int OUT_STAGES_MAX   = 4;
  localparam int IN_STAGES_MIN    = 1;
  localparam int IN_STAGES_MAX    = 3;
  localparam int GUARD_CYCLES_MAX = 7;

  function automatic bit lanes_ok(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  // All-ones mask of the requested width: every chip select deselected.
  function automatic logic [SS_WIDTH_MAX-1:0] ss_reset_value(input int width);
    logic [SS_WIDTH_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < SS_WIDTH_MAX; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_io_lane_guard.sv
`default_nettype none
// ============================================================================
// spi_io_lane_guard : per-lane bus-turnaround guard counter and pad OE gating
// Revision          : 1.0
// ============================================================================
module spi_io_lane_guard
  import spi_io_pkg::*;
#(
  parameter int GUARD_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic oe_pre_i,
  input  logic oe_q_i,
  input  logic lb_q_i,
  output logic guard_active_o,
  output logic pad_oe_o
);

  localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES);

  logic [GUARD_CNT_W-1:0] cnt_q;
  logic [GUARD_CNT_W-1:0] cnt_d;

  // Load when an OE rise is about to reach the pad; a low OE aborts any guard.
  always_comb begin
    cnt_d = cnt_q;
    if (oe_pre_i && !oe_q_i) begin
      cnt_d = GUARD_LOAD;
    end else if (!oe_q_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign guard_active_o = (cnt_q != '0);
  assign pad_oe_o       = oe_q_i & ~guard_active_o & ~lb_q_i;

endmodule
`default_nettype wire

// File: rtl/spi_io_pipe.sv
`default_nettype none
// ============================================================================
// spi_io_pipe : generic STAGES-deep register pipe with a settable reset value
// Revision    : 1.0
// ============================================================================
module spi_io_pipe #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_io_retimer.sv
`default_nettype none
// ============================================================================
// spi_io_retimer : pad-side SPI/QSPI retiming with turnaround guard and loopback
// Revision       : 1.0
// ============================================================================
module spi_io_retimer
  import spi_io_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int SS_WIDTH     = 1,
  parameter int OUT_STAGES   = 1,
  parameter int IN_STAGES    = 1,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                io_systemClk,
  input  logic                io_systemReset,
  input  logic                spi_sclk_write,
  input  logic [SS_WIDTH-1:0] spi_ss,
  input  logic [LANES-1:0]    spi_data_write,
  input  logic [LANES-1:0]    spi_data_writeEnable,
  output logic [LANES-1:0]    spi_data_read,
  input  logic                loopback_en,
  output logic                pad_sclk_write,
  output logic [SS_WIDTH-1:0] pad_ss,
  output logic [LANES-1:0]    pad_data_write,
  output logic [LANES-1:0]    pad_data_writeEnable,
  input  logic [LANES-1:0]    pad_data_read,
  output logic [LANES-1:0]    guard_active
);

  localparam bit PARAMS_OK =
      lanes_ok(LANES) &&
      (SS_WIDTH >= 1) && (SS_WIDTH <= SS_WIDTH_MAX) &&
      (OUT_STAGES >= OUT_STAGES_MIN) && (OUT_STAGES <= OUT_STAGES_MAX) &&
      (IN_STAGES >= IN_STAGES_MIN) && (IN_STAGES <= IN_STAGES_MAX) &&
      (GUARD_CYCLES >= 0) && (GUARD_CYCLES <= GUARD_CYCLES_MAX);

  localparam logic [SS_WIDTH-1:0] SS_RST = SS_WIDTH'(ss_reset_value(SS_WIDTH));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("spi_io_retimer: parameter out of range");
    end
  endgenerate

  logic                sclk_q;
  logic [SS_WIDTH-1:0] ss_q;
  logic [LANES-1:0]    data_q;
  logic [LANES-1:0]    oe_pre;
  logic [LANES-1:0]    oe_q;
  logic [LANES-1:0]    in_src;
  logic                lb_q;

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) lb_q <= 1'b0;
    else                lb_q <= loopback_en;
  end

  spi_io_pipe #(.WIDTH(1), .STAGES(OUT_STAGES), .RST_VAL(1'b0)) u_sclk_pipe (
    .clk_i(io_systemClk), .rst_i(io_systemReset), .d_i(spi_sclk_write), .q_o(sclk_q)
  );

  spi_io_pipe #(.WIDTH(SS_WIDTH), .STAGES(OUT_STAGES), .RST_VAL(SS_RST)) u_ss_pipe (
    .clk_i(io_systemClk), .rst_i(io_systemReset), .d_i(spi_ss), .q_o(ss_q)
  );

  spi_io_pipe #(.WIDTH(LANES), .STAGES(OUT_STAGES), .RST_VAL('0)) u_data_pipe (
    .clk_i(io_systemClk), .rst_i(io_systemReset), .d_i(spi_data_write), .q_o(data_q)
  );

  // OE pipe is split so the guard can see the value entering the last stage.
  generate
    if (OUT_STAGES == 1) begin : g_oe_direct
      assign oe_pre = spi_data_writeEnable;
    end else begin : g_oe_front
      spi_io_pipe #(.WIDTH(LANES), .STAGES(OUT_STAGES-1), .RST_VAL('0)) u_oe_front (
        .clk_i(io_systemClk), .rst_i(io_systemReset), .d_i(spi_data_writeEnable), .q_o(oe_pre)
      );
    end
  endgenerate

  spi_io_pipe #(.WIDTH(LANES), .STAGES(1), .RST_VAL('0)) u_oe_last (
    .clk_i(io_systemClk), .rst_i(io_systemReset), .d_i(oe_pre), .q_o(oe_q)
  );

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      spi_io_lane_guard #(.GUARD_CYCLES(GUARD_CYCLES)) u_guard (
        .clk_i          (io_systemClk),
        .rst_i          (io_systemReset),
        .oe_pre_i       (oe_pre[k]),
        .oe_q_i         (oe_q[k]),
        .lb_q_i         (lb_q),
        .guard_active_o (guard_active[k]),
        .pad_oe_o       (pad_data_writeEnable[k])
      );
    end
  endgenerate

  assign in_src = lb_q ? data_q : pad_data_read;

  spi_io_pipe #(.WIDTH(LANES), .STAGES(IN_STAGES), .RST_VAL('0)) u_in_pipe (
    .clk_i(io_systemClk), .rst_i(io_systemReset), .d_i(in_src), .q_o(spi_data_read)
  );

  assign pad_sclk_write = sclk_q & ~lb_q;
  assign pad_ss         = ss_q | {SS_WIDTH{lb_q}};
  assign pad_data_write = data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_io_retimer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_io_retimer : scoreboard bench for two retimer configurations
// Revision          : 1.0
// ============================================================================
module tb_spi_io_retimer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sclk, lb;
  logic [0:0] ss;
  logic [3:0] dw, oe, pdr;

  logic       a_sclk, b_sclk;
  logic [0:0] a_ss, b_ss;
  logic [3:0] a_pdw, a_poe, a_pdr, a_ga;
  logic [3:0] b_pdw, b_poe, b_pdr, b_ga;

  // dut_a: 2 out / 2 in stages, no guard.  dut_b: 1 / 1 stages, 3-cycle guard.
  spi_io_retimer #(.LANES(4), .SS_WIDTH(1), .OUT_STAGES(2), .IN_STAGES(2), .GUARD_CYCLES(0)) dut_a (
    .io_systemClk(clk), .io_systemReset(rst), .spi_sclk_write(sclk), .spi_ss(ss),
    .spi_data_write(dw), .spi_data_writeEnable(oe), .spi_data_read(a_pdr),
    .loopback_en(lb), .pad_sclk_write(a_sclk), .pad_ss(a_ss), .pad_data_write(a_pdw),
    .pad_data_writeEnable(a_poe), .pad_data_read(pdr), .guard_active(a_ga)
  );

  spi_io_retimer #(.LANES(4), .SS_WIDTH(1), .OUT_STAGES(1), .IN_STAGES(1), .GUARD_CYCLES(3)) dut_b (
    .io_systemClk(clk), .io_systemReset(rst), .spi_sclk_write(sclk), .spi_ss(ss),
    .spi_data_write(dw), .spi_data_writeEnable(oe), .spi_data_read(b_pdr),
    .loopback_en(lb), .pad_sclk_write(b_sclk), .pad_ss(b_ss), .pad_data_write(b_pdw),
    .pad_data_writeEnable(b_poe), .pad_data_read(pdr), .guard_active(b_ga)
  );

  localparam int A_SCLK = 0, A_SS = 1, A_PDW = 2, A_POE = 3, A_PDR = 4, A_GA = 5;
  localparam int B_SCLK = 6, B_SS = 7, B_PDW = 8, B_POE = 9, B_PDR = 10, B_GA = 11;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] actual(input int sig);
    case (sig)
      A_SCLK: return {3'b000, a_sclk};
      A_SS:   return {3'b000, a_ss};
      A_PDW:  return a_pdw;
      A_POE:  return a_poe;
      A_PDR:  return a_pdr;
      A_GA:   return a_ga;
      B_SCLK: return {3'b000, b_sclk};
      B_SS:   return {3'b000, b_ss};
      B_PDW:  return b_pdw;
      B_POE:  return b_poe;
      B_PDR:  return b_pdr;
      B_GA:   return b_ga;
      default: return 4'hx;
    endcase
  endfunction

  // Expected value for output 'sig' dly cycles after the current one.
  task automatic expect_at(input int dly, input int sig, input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = actual(sb[i].sig);
        checks++;
        if (sb[i].cyc < cyc || act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s @cyc %0d: actual=%h required=%h", sb[i].name, sb[i].cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1; sclk = 1'b1; ss = 1'b0; dw = 4'hF; oe = 4'hF; pdr = 4'hF; lb = 1'b0;
    step(2);
    expect_at(0, A_SS, 4'h1, "rst_a_ss");    expect_at(0, A_SCLK, 4'h0, "rst_a_sclk");
    expect_at(0, A_PDW, 4'h0, "rst_a_pdw");  expect_at(0, A_POE, 4'h0, "rst_a_poe");
    expect_at(0, A_PDR, 4'h0, "rst_a_pdr");  expect_at(0, A_GA, 4'h0, "rst_a_ga");
    expect_at(0, B_SS, 4'h1, "rst_b_ss");    expect_at(0, B_PDW, 4'h0, "rst_b_pdw");
    expect_at(0, B_POE, 4'h0, "rst_b_poe");  expect_at(0, B_PDR, 4'h0, "rst_b_pdr");
    expect_at(0, B_GA, 4'h0, "rst_b_ga");

    rst = 1'b0; sclk = 1'b0; ss = 1'b1; dw = 4'h0; oe = 4'h0; pdr = 4'h0;
    step(1);

    // Latency
    sclk = 1'b1; ss = 1'b0; dw = 4'hA; pdr = 4'h5;
    expect_at(1, A_PDW, 4'h0, "lat_a_pdw_early"); expect_at(2, A_PDW, 4'hA, "lat_a_pdw");
    expect_at(1, A_PDR, 4'h0, "lat_a_pdr_early"); expect_at(2, A_PDR, 4'h5, "lat_a_pdr");
    expect_at(2, A_SCLK, 4'h1, "lat_a_sclk");
    expect_at(1, A_SS, 4'h1, "lat_a_ss_early");   expect_at(2, A_SS, 4'h0, "lat_a_ss");
    expect_at(1, B_PDW, 4'hA, "lat_b_pdw");       expect_at(1, B_PDR, 4'h5, "lat_b_pdr");
    expect_at(1, B_SS, 4'h0, "lat_b_ss");
    step(3);

    // OE rise: guarded on dut_b, immediate on dut_a
    oe = 4'h1;
    for (int d = 1; d <= 3; d++) begin
      expect_at(d, B_GA, 4'h1, "guard_b_ga");
      expect_at(d, B_POE, 4'h0, "guard_b_poe_held");
    end
    expect_at(4, B_GA, 4'h0, "guard_b_ga_end");
    expect_at(4, B_POE, 4'h1, "guard_b_poe");
    expect_at(1, A_POE, 4'h0, "g0_a_poe_early");
    expect_at(2, A_POE, 4'h1, "g0_a_poe");
    for (int d = 1; d <= 4; d++) expect_at(d, A_GA, 4'h0, "g0_a_ga");
    step(5);

    // Guard abort and restart
    oe = 4'h0;
    step(2);
    oe = 4'h1;
    expect_at(1, B_GA, 4'h1, "abort_b_ga_rise");
    step(1);
    oe = 4'h0;
    expect_at(1, B_GA, 4'h1, "abort_b_ga_hold");
    expect_at(2, B_GA, 4'h0, "abort_b_ga_clear");
    for (int d = 0; d <= 3; d++) expect_at(d, B_POE, 4'h0, "abort_b_poe");
    step(2);
    oe = 4'h1;
    for (int d = 1; d <= 3; d++) begin
      expect_at(d, B_GA, 4'h1, "restart_b_ga");
      expect_at(d, B_POE, 4'h0, "restart_b_poe_held");
    end
    expect_at(4, B_GA, 4'h0, "restart_b_ga_end");
    expect_at(4, B_POE, 4'h1, "restart_b_poe");
    expect_at(1, A_GA, 4'h0, "restart_a_ga");
    step(5);

    // Loopback entry
    lb = 1'b1; dw = 4'hC; pdr = 4'h3;
    expect_at(1, B_SS, 4'h1, "lb_b_ss");     expect_at(1, B_POE, 4'h0, "lb_b_poe");
    expect_at(1, B_SCLK, 4'h0, "lb_b_sclk"); expect_at(1, B_PDW, 4'hC, "lb_b_pdw");
    expect_at(2, B_PDR, 4'hC, "lb_b_pdr");   expect_at(4, B_PDR, 4'hC, "lb_b_pdr_hold");
    expect_at(1, A_SS, 4'h1, "lb_a_ss");     expect_at(1, A_POE, 4'h0, "lb_a_poe");
    expect_at(2, A_PDR, 4'h3, "lb_a_pdr_pad"); expect_at(3, A_PDR, 4'hA, "lb_a_pdr_stale");
    expect_at(4, A_PDR, 4'hC, "lb_a_pdr");
    step(5);

    // Loopback exit
    lb = 1'b0;
    expect_at(1, B_SS, 4'h0, "lbx_b_ss");    expect_at(1, B_POE, 4'h1, "lbx_b_poe");
    expect_at(1, B_SCLK, 4'h1, "lbx_b_sclk"); expect_at(1, B_PDR, 4'hC, "lbx_b_pdr_drain");
    expect_at(2, B_PDR, 4'h3, "lbx_b_pdr");  expect_at(1, A_POE, 4'h1, "lbx_a_poe");
    step(3);

    // Reset mid-transfer
    oe = 4'hF; rst = 1'b1;
    expect_at(1, A_SS, 4'h1, "mrst_a_ss");   expect_at(1, A_POE, 4'h0, "mrst_a_poe");
    expect_at(1, A_PDR, 4'h0, "mrst_a_pdr"); expect_at(1, A_SCLK, 4'h0, "mrst_a_sclk");
    expect_at(1, B_SS, 4'h1, "mrst_b_ss");   expect_at(1, B_POE, 4'h0, "mrst_b_poe");
    expect_at(1, B_PDR, 4'h0, "mrst_b_pdr"); expect_at(1, B_GA, 4'h0, "mrst_b_ga");
    expect_at(1, B_PDW, 4'h0, "mrst_b_pdw"); expect_at(1, B_SCLK, 4'h0, "mrst_b_sclk");
    step(2);
    rst = 1'b0;
    step(3);

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: actual=%0d required=0 pending", sb.size());
      errors++;
      checks++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_io_retimer.md
# spi_io_retimer

Parametrised pad-side retiming stage between the SoC SPI/QSPI master core and the FPGA GPIO pads, sitting in the top-level SoC wrapper. It does four things:
- registers the core's sclk, chip-select, per-lane data and output-enable through a configurable output pipeline;
- resynchronises pad read data through a configurable input pipeline;
- enforces a per-lane bus-turnaround guard so the FPGA never drives a lane the flash may still be driving;
- provides an internal loopback mode for self-test without pad activity.

## Interface
Parameters
- LANES, 4: data lanes (1, 2 or 4; 2 = dual, 4 = quad).
- SS_WIDTH, 1: number of active-low chip selects.
- OUT_STAGES, 1: core-to-pad register stages, 1..4.
- IN_STAGES, 1: pad-to-core register stages, 1..3.
- GUARD_CYCLES, 1: turnaround guard length in cycles, 0..7.

Ports
- io_systemClk  in  1  system clock; one clock; reset is synchronous and active-high.
- io_systemReset  in  1  synchronous active-high reset.
- spi_sclk_write  in  1  core SPI clock.
- spi_ss  in  SS_WIDTH  core chip selects, active low.
- spi_data_write  in  LANES  core output data.
- spi_data_writeEnable  in  LANES  core per-lane output enable.
- spi_data_read  out  LANES  resynchronised read data to core.
- loopback_en  in  1  1 = internal loopback, pads quiesced.
- pad_sclk_write  out  1  to pad.
- pad_ss  out  SS_WIDTH  to pad.
- pad_data_write  out  LANES  to pad.
- pad_data_writeEnable  out  LANES  to pad tristate control.
- pad_data_read  in  LANES  from pad.
- guard_active  out  LANES  1 while a lane's turnaround guard suppresses OE.

## Operation
**Output pipeline**
- Each core output passes through OUT_STAGES flops; the final stage is named *_q.
- oe_pre = the OE pipeline input of the last stage. For OUT_STAGES=1 this is spi_data_writeEnable itself.

**Guard, per lane k (3-bit counter cnt[k])**
- oe_pre[k]=1 and oe_q[k]=0 (rise about to reach the pad): cnt[k] <= GUARD_CYCLES.
- Else if oe_q[k]=0: cnt[k] <= 0. This aborts a running guard if OE falls mid-guard.
- Else if cnt[k]!=0: cnt[k] <= cnt[k]-1.
- guard_active[k] = (cnt[k]!=0), decoded directly from the flop.
- pad_data_writeEnable[k] = oe_q[k] & ~guard_active[k] & ~lb_q.
  - This is an AND of registered terms only.
  - OE falling edges are never delayed beyond OUT_STAGES.
- With GUARD_CYCLES=0 the guard is inert and guard_active stays 0.

**Loopback**
- loopback_en is registered into lb_q, so it takes effect one cycle after it changes.
- While lb_q=1:
  - pad_sclk_write=0 and pad_ss all ones.
  - pad_data_writeEnable=0.
  - pad_data_write still carries the pipelined data.
  - The input pipeline is fed from data_q instead of pad_data_read.
- Pipelines are not flushed on a mode change; stale samples drain within IN_STAGES cycles.

**Input pipeline**
- IN_STAGES flops from the selected source (pad_data_read or data_q) to spi_data_read.

**Reset**
- Every flop clears on the io_systemReset clock edge, except the ss pipeline stages, which set to all ones (deselected).
- Reset applies mid-transfer with no other condition: it immediately quiesces the bus.

## Timing
- Core-to-pad latency is OUT_STAGES cycles for sclk, ss, data and OE falls.
- OE rise latency is OUT_STAGES+GUARD_CYCLES cycles.
- Pad-to-core latency is IN_STAGES cycles.
- Loopback core write to spi_data_read is OUT_STAGES+IN_STAGES cycles.
- Reset values:
  - pad_sclk_write=0, pad_ss=all ones, pad_data_write=0, pad_data_writeEnable=0.
  - spi_data_read=0, guard_active=0, cnt=0, lb_q=0.
- Simultaneous events:
  - oe_pre rise while oe_q already 1: no reload.
  - Reset wins over every other update.
- There is no handshake: the block is a fixed-latency pipe, and the core's SPI clock divider absorbs the latency.

## Structure
- spi_io_pkg holds:
  - the guard counter width constant (3);
  - the parameter-range check localparams;
  - the SS reset value function.
- Sub-module spi_io_lane_guard holds the per-lane counter and OE gating, instantiated LANES times.
- The top instantiates a generic pipe for the sclk, ss, data, OE and input paths.
- Elaboration fails if any parameter is out of range.

## Test plan
- **Reset:** assert io_systemReset mid-transfer with spi_ss=0 and OE=1 -> next cycle pad_ss=1, pad_data_writeEnable=0, spi_data_read=0, guard_active=0.
- **Latency:** OUT_STAGES=2, IN_STAGES=2; drive spi_data_write=4'hA, pad_data_read=4'h5 -> pad_data_write=4'hA after 2 cycles, spi_data_read=4'h5 after 2 cycles.
- **Guard:** GUARD_CYCLES=3, OUT_STAGES=1; spi_data_writeEnable[0] 0->1 at cycle t -> guard_active[0]=1 for cycles t+1..t+3, pad_data_writeEnable[0]=1 from t+4.
- **Guard abort:** OE falls at t+2 of the above -> pad OE stays 0 and guard_active[0] clears by t+3; a re-rise restarts a full 3-cycle guard.
- **Loopback:** set loopback_en=1 and drive spi_data_write=4'hC with OUT_STAGES=1, IN_STAGES=1 -> pad_ss all ones, pad OE=0, spi_data_read=4'hC two cycles later, pad_data_read ignored.
- **GUARD_CYCLES=0:** OE rise reaches the pad in OUT_STAGES cycles and guard_active never asserts.
